// File: rtl/muldiv_sequencer_pkg.sv
// Shared encodings for the multi-cycle M-extension unit: ALU select codes,
// sequencer state encoding and op-classification helpers.
package muldiv_sequencer_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_sel_e;

  typedef enum logic [2:0] {
    MD_IDLE    = 3'd0,
    MD_MUL     = 3'd1,
    MD_DIV     = 3'd2,
    MD_FIX     = 3'd3,
    MD_SPECIAL = 3'd4
  } md_state_t;

  function automatic logic is_mext(input logic [4:0] sel);
    return (sel >= ALU_MUL) && (sel <= ALU_REMU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] sel);
    return (sel >= ALU_DIV) && (sel <= ALU_REMU);
  endfunction

  function automatic logic rs1_signed(input logic [4:0] sel);
    return (sel == ALU_MULH) || (sel == ALU_MULHSU) || (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

  function automatic logic rs2_signed(input logic [4:0] sel);
    return (sel == ALU_MULH) || (sel == ALU_DIV) || (sel == ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring radix-2 division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep the difference only when it is non-negative.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] next_rem,
  output logic [XLEN-1:0] next_quo
);

  logic [XLEN:0] shifted_s;
  logic [XLEN:0] trial_s;

  // Trial subtraction; bit XLEN of the difference is the borrow (negative result).
  always_comb begin
    shifted_s = {rem, quo[XLEN-1]};
    trial_s   = shifted_s - {1'b0, divisor};
    if (trial_s[XLEN]) begin
      next_rem = shifted_s[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b0};
    end else begin
      next_rem = trial_s[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution controller: one-cycle multiply, 32-step restoring
// divide with sign fix-up, and a fast path for divide-by-zero / overflow.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      SELECT,
  input  logic [XLEN-1:0] DATA1,
  input  logic [XLEN-1:0] DATA2,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT
);

  md_state_t         state_r;
  logic [4:0]        sel_r;
  logic [XLEN-1:0]   op_a_r;
  logic [XLEN-1:0]   op_b_r;
  logic              sa_r;
  logic              sb_r;
  logic              neg_a_r;
  logic              neg_b_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   quo_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              done_r;
  logic [XLEN-1:0]   result_r;

  logic              neg_a_s;
  logic              neg_b_s;
  logic [XLEN-1:0]   abs_a_s;
  logic [XLEN-1:0]   abs_b_s;
  logic              div_zero_s;
  logic              div_ovf_s;
  logic [2*XLEN-1:0] ma_s;
  logic [2*XLEN-1:0] mb_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_res_s;
  logic [XLEN-1:0]   fix_res_s;
  logic [XLEN-1:0]   special_s;
  logic [XLEN-1:0]   rem_next_s;
  logic [XLEN-1:0]   quo_next_s;

  muldiv_div_step #(.XLEN(XLEN)) u_div_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (op_b_r),
    .next_rem (rem_next_s),
    .next_quo (quo_next_s)
  );

  // Operand classification at accept time.
  always_comb begin
    neg_a_s    = rs1_signed(SELECT) & DATA1[XLEN-1];
    neg_b_s    = rs2_signed(SELECT) & DATA2[XLEN-1];
    abs_a_s    = neg_a_s ? -DATA1 : DATA1;
    abs_b_s    = neg_b_s ? -DATA2 : DATA2;
    div_zero_s = (DATA2 == {XLEN{1'b0}});
    div_ovf_s  = ((SELECT == ALU_DIV) || (SELECT == ALU_REM)) &&
                 (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == {XLEN{1'b1}});
  end

  // Sign-extended operands make the low 2*XLEN bits of the product correct for every signedness mix.
  always_comb begin
    ma_s   = {{XLEN{sa_r & op_a_r[XLEN-1]}}, op_a_r};
    mb_s   = {{XLEN{sb_r & op_b_r[XLEN-1]}}, op_b_r};
    prod_s = ma_s * mb_s;
    if (sel_r == ALU_MUL) begin
      mul_res_s = prod_s[XLEN-1:0];
    end else begin
      mul_res_s = prod_s[2*XLEN-1:XLEN];
    end
  end

  // Sign fix-up: quotient negative when signs differ, remainder follows the dividend.
  always_comb begin
    if ((sel_r == ALU_DIV) || (sel_r == ALU_DIVU)) begin
      fix_res_s = (neg_a_r ^ neg_b_r) ? -quo_r : quo_r;
    end else begin
      fix_res_s = neg_a_r ? -rem_r : rem_r;
    end
  end

  // Architected results for divide-by-zero and signed overflow (divisor held as |DATA2|).
  always_comb begin
    if (op_b_r == {XLEN{1'b0}}) begin
      if ((sel_r == ALU_DIV) || (sel_r == ALU_DIVU)) begin
        special_s = {XLEN{1'b1}};
      end else begin
        special_s = op_a_r;
      end
    end else begin
      if (sel_r == ALU_DIV) begin
        special_s = {1'b1, {(XLEN-1){1'b0}}};
      end else begin
        special_s = {XLEN{1'b0}};
      end
    end
  end

  // Sequencer FSM with registered DONE/RESULT; FLUSH overrides everything.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r  <= MD_IDLE;
      sel_r    <= 5'd0;
      op_a_r   <= {XLEN{1'b0}};
      op_b_r   <= {XLEN{1'b0}};
      sa_r     <= 1'b0;
      sb_r     <= 1'b0;
      neg_a_r  <= 1'b0;
      neg_b_r  <= 1'b0;
      rem_r    <= {XLEN{1'b0}};
      quo_r    <= {XLEN{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      done_r   <= 1'b0;
      result_r <= {XLEN{1'b0}};
    end else if (FLUSH) begin
      state_r <= MD_IDLE;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (START && is_mext(SELECT)) begin
            sel_r   <= SELECT;
            op_a_r  <= DATA1;
            sa_r    <= rs1_signed(SELECT);
            sb_r    <= rs2_signed(SELECT);
            neg_a_r <= neg_a_s;
            neg_b_r <= neg_b_s;
            if (!is_div_op(SELECT)) begin
              op_b_r  <= DATA2;
              state_r <= MD_MUL;
            end else begin
              op_b_r <= abs_b_s;
              if (div_zero_s || div_ovf_s) begin
                state_r <= MD_SPECIAL;
              end else begin
                rem_r   <= {XLEN{1'b0}};
                quo_r   <= abs_a_s;
                cnt_r   <= {CNT_W{1'b0}};
                state_r <= MD_DIV;
              end
            end
          end
        end
        MD_MUL: begin
          result_r <= mul_res_s;
          done_r   <= 1'b1;
          state_r  <= MD_IDLE;
        end
        MD_DIV: begin
          rem_r <= rem_next_s;
          quo_r <= quo_next_s;
          cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_r == CNT_W'(XLEN-1)) begin
            state_r <= MD_FIX;
          end
        end
        MD_FIX: begin
          result_r <= fix_res_s;
          done_r   <= 1'b1;
          state_r  <= MD_IDLE;
        end
        MD_SPECIAL: begin
          result_r <= special_s;
          done_r   <= 1'b1;
          state_r  <= MD_IDLE;
        end
        default: begin
          state_r <= MD_IDLE;
        end
      endcase
    end
  end

  assign BUSY   = (state_r != MD_IDLE);
  assign DONE   = done_r;
  assign RESULT = result_r;

endmodule
